// File: rtl/crc7_encode_if.sv
// Handshake bundle for the CRC-7 encoder: word-in channel and codeword-out channel.
// The master side drives words and consumes codewords; the encoder is the slave.
interface crc7_encode_if #(
    parameter int DATA_W = 16,
    parameter int CRC_W  = 7
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        data_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W+CRC_W-1:0]  code_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, code_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, code_out
    );
endinterface

// File: rtl/crc7_encode.sv
// Bit-serial CRC-7 encoder (G = x^7+x^3+1), MSB first, no init/reflect/xorout.
// Emits {message, crc} so every codeword divides evenly by G.
module crc7_encode #(
    parameter int                 DATA_W = 16,
    parameter int                 CRC_W  = 7,
    parameter logic [CRC_W-1:0]   POLY   = 7'b0001001
) (
    input  logic               clk,
    input  logic               reset,
    crc7_encode_if.slave       bus,
    output logic               o_busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    r_state, w_state_next;
    logic [DATA_W-1:0]         r_msg, w_msg_next;
    logic [DATA_W-1:0]         r_shift, w_shift_next;
    logic [CRC_W-1:0]          r_crc, w_crc_next;
    logic [CNT_W-1:0]          r_cnt, w_cnt_next;
    logic [DATA_W+CRC_W-1:0]   r_code, w_code_next;

    logic                      w_fb;
    logic [CRC_W-1:0]          w_crc_step;

    // One LFSR step: shift left, fold the generator in where the feedback bit is set.
    assign w_fb = r_crc[CRC_W-1] ^ r_shift[DATA_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < CRC_W; gi++) begin : g_crc
            if (gi == 0) begin : g_lsb
                assign w_crc_step[gi] = w_fb & POLY[gi];
            end else begin : g_upper
                assign w_crc_step[gi] = r_crc[gi-1] ^ (w_fb & POLY[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_msg   <= '0;
            r_shift <= '0;
            r_crc   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_next;
            r_msg   <= w_msg_next;
            r_shift <= w_shift_next;
            r_crc   <= w_crc_next;
            r_cnt   <= w_cnt_next;
            r_code  <= w_code_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_msg_next   = r_msg;
        w_shift_next = r_shift;
        w_crc_next   = r_crc;
        w_cnt_next   = r_cnt;
        w_code_next  = r_code;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_msg_next   = bus.data_in;
                    w_shift_next = bus.data_in;
                    w_crc_next   = '0;
                    w_cnt_next   = '0;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_crc_next   = w_crc_step;
                w_shift_next = r_shift << 1;
                w_cnt_next   = r_cnt + 1'b1;
                // The final bit's remainder goes straight into the codeword.
                if (r_cnt == LAST_BIT) begin
                    w_code_next  = {r_msg, w_crc_step};
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.code_out  = r_code;
    assign o_busy        = (r_state != IDLE);
endmodule

// File: doc/crc7_encode.md
Name: crc7_encode

Overview:
- Bit-serial CRC-7 encoder that produces the transmit-side codeword for the team's CRC-7 link.
- Accepts a 16-bit data word over a valid/ready handshake and computes a 7-bit CRC with generator G(x)=x^7+x^3+1 (full form 8'b10001001), MSB first.
- Emits a 23-bit codeword {data[15:0], crc[6:0]} over a second valid/ready handshake.
- Every emitted codeword leaves a zero remainder when divided by G. This is the framing the CRC-7 decode stage checks.

Parameters:
- DATA_W, 16, message width in bits; the bit counter is sized from it.
- CRC_W, 7, CRC width in bits.
- POLY, 7'b0001001, generator low-order coefficients (x^7 term implicit).

Ports:
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  data_in is valid this cycle
- in_ready  output  1  encoder can accept a word
- data_in  input  DATA_W  message word, sampled only on accept
- out_valid  output  1  code_out holds a completed codeword
- out_ready  input  1  downstream takes code_out this cycle
- code_out  output  DATA_W+CRC_W  {message, crc}, message in upper bits
- busy  output  1  high while not IDLE

Behaviour:
- Reset and clock: reset (synchronous, active-high) on clk. While reset is high at an edge:
  - state<=IDLE; crc reg, shift reg and bit counter <=0.
  - out_valid=0, code_out=0, busy=0, in_ready=1 after the edge.
  - Reset mid-SHIFT or in DONE discards the word; no partial output is ever flagged valid.
- States: IDLE, SHIFT, DONE. Outputs in_ready=(state==IDLE), out_valid=(state==DONE), busy=(state!=IDLE), all decoded from registered state.
- IDLE:
  - On in_valid&&in_ready: latch data_in into the message reg and the shift reg, crc<=0, cnt<=0, go to SHIFT.
  - Without in_valid: stay in IDLE.
- SHIFT: one message bit per clock, MSB first.
  - fb = crc[CRC_W-1] ^ shift[DATA_W-1].
  - crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - shift <= shift<<1; cnt<=cnt+1.
  - After the edge that processes bit index DATA_W-1 (cnt==DATA_W-1): load code_out <= {message, next crc}, go to DONE.
- Latency: accept edge E0; bits are processed on edges E1..E16; out_valid is high in the cycle following E16, i.e. 16 cycles after accept.
- DONE:
  - Hold code_out and out_valid stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE.
  - code_out keeps its last value in IDLE; it is only meaningful while out_valid=1.
- Throughput: one word per DATA_W+2 cycles minimum (accept, 16 shifts, handoff). There is no overlap, because in_ready is low in SHIFT and DONE.
- data_in changes while busy are ignored. in_valid held high while busy causes no action until IDLE.
- out_ready high outside DONE has no effect.
- The CRC is the remainder of data·x^7 mod G, with no init value, no reflection and no final XOR. data=0 gives crc=0.

Test Plan:
- Basic: reset; send 0x0001 -> exactly 16 cycles after the accept edge, out_valid=1 and code_out=23'h000089 (crc 7'h09); busy=1 for the whole interval.
- Linearity: 0x0002 -> 23'h000112 (crc 7'h12); 0x0003 -> 23'h00019B (crc 7'h1B); 0x0000 -> 23'h000000.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> code_out and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Input stability: change data_in to 0xFFFF and pulse in_valid during SHIFT of word 0x0001 -> result is still 23'h000089 and no second word is accepted.
- Reset mid-operation: assert reset at the 8th SHIFT cycle -> next cycle in IDLE with out_valid=0, code_out=0, in_ready=1. A new word 0x0002 then encodes to 23'h000112.
- Randomized: 1000 random words with random out_ready -> each code_out[22:7]==data, and code_out mod G == 0 per a reference model.
